axi4_lite_read_slave_responder: RTL
===================================

Name: axi4_lite_read_slave_responder

Overview:
Synthesizable AXI4-Lite read-channel responder (slave side) for the Axi4Lite read VIP bench, driven by the read master agent. It accepts AR transactions, returns data from an internal word-addressed register file, and generates OKAY, SLVERR or DECERR responses. Programmable per-transaction ARREADY/RVALID delays exercise master wait-state handling. A backdoor write port preloads the register file.

Parameters:
ADDRESS_WIDTH, 32, araddr width
DATA_WIDTH, 32, rdata width; fixed at 32 (word = 4 bytes)
DELAY_WIDTH, 5, width of delay inputs
MIN_ADDRESS, 'h00, lowest decoded byte address (4-byte aligned)
MAX_ADDRESS, 'hFF, highest decoded byte address; DEPTH = (MAX_ADDRESS-MIN_ADDRESS+1)/4 = 64 (localparam)
DEFAULT_READY, 0, 1 = ARREADY held high while idle (zero-wait accept)

Ports:
aclk  in  1  clock
areset  in  1  synchronous, active-high reset
araddr  in  ADDRESS_WIDTH  read address
arprot  in  3  protection type (captured, no access check)
arvalid  in  1  address valid
arready  out  1  address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR (01 EXOKAY never issued)
rvalid  out  1  read data valid
rready  in  1  master ready
arready_delay  in  DELAY_WIDTH  wait cycles before ARREADY (DEFAULT_READY=0 only)
rvalid_delay  in  DELAY_WIDTH  wait cycles between AR handshake and RVALID
mem_wr_en  in  1  backdoor write enable
mem_wr_idx  in  $clog2(DEPTH)  backdoor word index
mem_wr_data  in  DATA_WIDTH  backdoor data
rd_count  out  16  completed R handshakes, wraps at 0xFFFF->0
err_count  out  16  completed R handshakes with rresp != OKAY, wraps
protocol_err  out  1  sticky: arvalid dropped before handshake

Behaviour:
- Reset (areset=1 at a posedge): state IDLE; arready=0, rvalid=0, rdata=0, rresp=00, counters=0, protocol_err=0, register file cleared to 0. Mid-transaction reset aborts it; no R beat is issued for it. arready=DEFAULT_READY from the first cycle after reset deasserts.
- One outstanding transaction. FSM states: IDLE, AR_WAIT, R_DELAY, R_VALID.
- IDLE, DEFAULT_READY=1: arready=1. arvalid=1 completes the handshake at that edge; go to R_DELAY, or to R_VALID if rvalid_delay=0.
- IDLE, DEFAULT_READY=0: arready=0. arvalid=1 loads the counter with arready_delay; go to AR_WAIT.
- AR_WAIT: counter decrements each cycle; arready=1 once counter==0. Handshake when arvalid&&arready. arvalid seen at edge t gives arready high in cycle t+1+arready_delay.
- AR handshake edge: capture araddr; set arready=0. Decode, in priority order:
  - araddr<MIN_ADDRESS or >MAX_ADDRESS: DECERR, rdata=0
  - araddr[1:0]!=0: SLVERR, rdata=0
  - otherwise OKAY, rdata=mem[(araddr-MIN_ADDRESS)>>2]
- rdata/rresp are registered at the handshake edge. A backdoor write at that same edge is not visible; the old data is returned.
- R_DELAY: counter loaded with rvalid_delay and decremented; go to R_VALID when it reaches 0. rvalid rises rvalid_delay+1 cycles after the AR handshake edge.
- R_VALID: rvalid=1; rdata/rresp held stable until rready. On the rvalid&&rready edge: rvalid=0, rd_count++, err_count++ if rresp!=00; go to IDLE.
  - With DEFAULT_READY=1, arready returns 1 in the cycle after the R handshake. No AR is accepted while rvalid=1.
- protocol_err: set if arvalid falls in AR_WAIT before the handshake. FSM returns to IDLE; no response is issued.
- Delay inputs are sampled only at state entry (AR_WAIT / R_DELAY).
- mem_wr_en writes at any time, independent of the FSM.
- Counters wrap silently.

Test Plan:
1. DEFAULT_READY=0, both delays 0, mem[3]=0xDEADBEEF; AR 0x0C (arvalid at edge t) -> arready high cycle t+1, rvalid high cycle t+2, rdata=0xDEADBEEF, rresp=00, rd_count=1.
2. arready_delay=5, rvalid_delay=3, rready low 4 cycles after rvalid -> arready on 6th cycle after arvalid; rvalid 4 cycles after handshake; rdata stable across stall; one completion.
3. AR 0x100 -> rresp=11, rdata=0; AR 0x0E -> rresp=10; err_count=2, rd_count=2.
4. DEFAULT_READY=1, back-to-back ARs with rready tied 1, delays 0 -> arready high in idle; each transaction 2 cycles; arready=0 while rvalid=1; 100 reads give rd_count=100.
5. Backdoor write mem[0]=0x1 at the same edge as AR 0x00 handshake (old value 0x0) -> rdata=0x0; next read of 0x00 returns 0x1.
6. areset pulsed in R_DELAY; separately, arvalid dropped in AR_WAIT -> reset: no rvalid, outputs at reset values. Drop: protocol_err=1 and sticky until reset.

Source files
------------

// File: rtl/axi4_lite_read_slave_responder.sv
// axi4_lite_read_slave_responder: AXI4-Lite read responder with register file, decode errors and programmable wait states
module axi4_lite_read_slave_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DELAY_WIDTH = 5,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = 'h00,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS = 'hFF,
  parameter logic DEFAULT_READY = 1'b0,
  localparam int DEPTH = int'((MAX_ADDRESS - MIN_ADDRESS + 1) / 4),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [2:0]               arprot,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic [DELAY_WIDTH-1:0]   arready_delay,
  input  logic [DELAY_WIDTH-1:0]   rvalid_delay,
  input  logic                     mem_wr_en,
  input  logic [IDX_W-1:0]         mem_wr_idx,
  input  logic [DATA_WIDTH-1:0]    mem_wr_data,
  output logic [15:0]              rd_count,
  output logic [15:0]              err_count,
  output logic                     protocol_err
);
  typedef enum logic [1:0] {IDLE, AR_WAIT, R_DELAY, R_VALID} state_t;
  localparam logic [ADDRESS_WIDTH-1:0] SPAN = MAX_ADDRESS - MIN_ADDRESS;
  state_t state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic arready_q, arready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;
  logic [15:0] rd_count_q, rd_count_d, err_count_q, err_count_d;
  logic perr_q, perr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDRESS_WIDTH:0] off;
  logic dec_err, slv_err, ar_hs, unused_ok;
  logic [IDX_W-1:0] rd_idx;
  // the extra top bit of off is the borrow, i.e. araddr below MIN_ADDRESS
  assign off = {1'b0, araddr} - {1'b0, MIN_ADDRESS};
  assign dec_err = off[ADDRESS_WIDTH] || (off[ADDRESS_WIDTH-1:0] > SPAN);
  assign slv_err = araddr[1:0] != 2'b00;
  assign rd_idx = off[IDX_W+1:2];
  assign ar_hs = arvalid && arready_q;
  assign unused_ok = ^arprot;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rd_count_d = rd_count_q;
    err_count_d = err_count_q;
    perr_d = perr_q;
    if (ar_hs) begin
      rresp_d = dec_err ? 2'b11 : slv_err ? 2'b10 : 2'b00;
      rdata_d = (dec_err || slv_err) ? '0 : mem_q[rd_idx];
      state_d = (rvalid_delay == '0) ? R_VALID : R_DELAY;
      cnt_d = rvalid_delay - 1'b1;
    end else begin
      case (state_q)
        IDLE: if (!DEFAULT_READY && arvalid) begin
          state_d = AR_WAIT;
          cnt_d = arready_delay;
        end
        AR_WAIT: if (!arvalid) begin
          perr_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        R_DELAY: if (cnt_q == '0) state_d = R_VALID;
                 else cnt_d = cnt_q - 1'b1;
        R_VALID: if (rready) begin
          state_d = IDLE;
          rd_count_d = rd_count_q + 16'd1;
          err_count_d = (rresp_q != 2'b00) ? err_count_q + 16'd1 : err_count_q;
        end
        default: state_d = IDLE;
      endcase
    end
    arready_d = (state_d == IDLE && DEFAULT_READY) || (state_d == AR_WAIT && cnt_d == '0);
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      arready_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
      rd_count_q <= '0;
      err_count_q <= '0;
      perr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      arready_q <= arready_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rd_count_q <= rd_count_d;
      err_count_q <= err_count_d;
      perr_q <= perr_d;
      if (mem_wr_en) mem_q[mem_wr_idx] <= mem_wr_data;
    end
  end
  assign arready = arready_q;
  assign rvalid = state_q == R_VALID;
  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign rd_count = rd_count_q;
  assign err_count = err_count_q;
  assign protocol_err = perr_q;
endmodule
